// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_arbiter: round-robin cpu/dbg arbiter onto the memory and IO buses   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int          TIMEOUT   = 16,
  parameter logic [7:0]  IO_PREFIX = 8'hFF,
  parameter logic [31:0] ERR_DATA  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        dbg_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        io_en,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata
);

  localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_IO   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner_dbg;
  logic        r_last_dbg;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [7:0]  r_cnt;
  logic [31:0] r_cpu_rdata;
  logic [31:0] r_dbg_rdata;
  logic        r_cpu_err;
  logic        r_dbg_err;

  logic        w_grant;
  logic        w_grant_dbg;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_done;
  logic        w_done_err;
  logic [31:0] w_done_data;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_dbg = 1'b0;
    w_sel_we    = cpu_we;
    w_sel_addr  = cpu_addr;
    w_sel_wdata = cpu_wdata;
    w_done      = 1'b0;
    w_done_err  = 1'b0;
    w_done_data = '0;
    case (r_state)
      S_IDLE: begin
        // On a tie the requester that did not win last time is served.
        if (cpu_req && dbg_req) begin
          w_grant_dbg = ~r_last_dbg;
        end else begin
          w_grant_dbg = dbg_req;
        end
        w_grant = cpu_req | dbg_req;
        if (w_grant_dbg) begin
          w_sel_we    = dbg_we;
          w_sel_addr  = dbg_addr;
          w_sel_wdata = dbg_wdata;
        end
        if (w_grant) begin
          w_state_nxt = (w_sel_addr[31:24] == IO_PREFIX) ? S_IO : S_MEM;
        end
      end
      S_MEM: begin
        // A ready arriving on the last allowed cycle still completes cleanly.
        if (mem_ready) begin
          w_state_nxt = S_RESP;
          w_done      = 1'b1;
          w_done_data = r_we ? 32'h0 : mem_rdata;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = S_RESP;
          w_done      = 1'b1;
          w_done_err  = 1'b1;
          w_done_data = ERR_DATA;
        end
      end
      S_IO: begin
        w_state_nxt = S_RESP;
        w_done      = 1'b1;
        w_done_data = r_we ? 32'h0 : io_rdata;
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_owner_dbg <= 1'b0;
      r_last_dbg  <= 1'b1;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
      r_cpu_err   <= 1'b0;
      r_dbg_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner_dbg <= w_grant_dbg;
        r_last_dbg  <= w_grant_dbg;
        r_we        <= w_sel_we;
        r_addr      <= w_sel_addr;
        r_wdata     <= w_sel_wdata;
      end
      if (r_state == S_MEM) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= '0;
      end
      // Each requester keeps its own response so it holds until its next ack.
      if (w_done) begin
        if (r_owner_dbg) begin
          r_dbg_rdata <= w_done_data;
          r_dbg_err   <= w_done_err;
        end else begin
          r_cpu_rdata <= w_done_data;
          r_cpu_err   <= w_done_err;
        end
      end
    end
  end

  assign mem_req   = (r_state == S_MEM);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign io_en     = (r_state == S_IO);
  assign io_we     = r_we;
  assign io_addr   = r_addr;
  assign io_wdata  = r_wdata;

  assign cpu_ack   = (r_state == S_RESP) & ~r_owner_dbg;
  assign dbg_ack   = (r_state == S_RESP) &  r_owner_dbg;
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;
  assign cpu_err   = r_cpu_err;
  assign dbg_err   = r_dbg_err;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_arbiter: scoreboard bench for the cpu/dbg memory arbiter         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam logic [31:0] c_MEM_KEY = 32'hCAFE_F04D;
  localparam logic [31:0] c_IO_KEY  = 32'h0F0F_0F0F;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack, cpu_err, cpu_stall;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic [31:0] dbg_rdata;
  logic        dbg_ack, dbg_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready = 1'b0;
  logic        io_en, io_we;
  logic [31:0] io_addr, io_wdata, io_rdata;

  always #5 clk = ~clk;

  // Memory returns addr ^ key; IO returns addr ^ another key.
  assign mem_rdata = mem_addr ^ c_MEM_KEY;
  assign io_rdata  = io_addr ^ c_IO_KEY;

  dmem_arbiter #(.TIMEOUT(16), .IO_PREFIX(8'hFF), .ERR_DATA(32'h0)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .io_en(io_en), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   mem_lat = 0;
  bit   chk_lat = 1'b0;
  bit   busy [2];
  int   t_drive [2];
  req_t pend_q [2][$];
  exp_t exp_q [2][$];
  int   ack_order [$];
  int   io_cnt = 0, memreq_cnt = 0, wait_cnt = 0;
  logic        last_io_we = 1'b0;
  logic [31:0] last_io_addr = '0, last_io_wdata = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t exp_for(input req_t r);
    exp_t e;
    if (r.addr[31:24] == 8'hFF) begin
      e.rdata = r.we ? 32'h0 : (r.addr ^ c_IO_KEY);
      e.err   = 1'b0;
      e.lat   = 2;
    end else if (mem_lat < 0) begin
      e.rdata = 32'h0;
      e.err   = 1'b1;
      e.lat   = 2 + 15;
    end else begin
      e.rdata = r.we ? 32'h0 : (r.addr ^ c_MEM_KEY);
      e.err   = 1'b0;
      e.lat   = 2 + mem_lat;
    end
    if (!chk_lat) e.lat = -1;
    return e;
  endfunction

  task automatic push(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d;
    pend_q[i].push_back(r);
  endtask

  task automatic service(input int i);
    logic        ack, err;
    logic [31:0] rd;
    exp_t        e;
    req_t        r;
    string       tg;
    tg  = (i == 0) ? "cpu" : "dbg";
    ack = (i == 0) ? cpu_ack : dbg_ack;
    err = (i == 0) ? cpu_err : dbg_err;
    rd  = (i == 0) ? cpu_rdata : dbg_rdata;
    if (i == 0) check("cpu_stall", 32'(cpu_stall), 32'(busy[0] & ~cpu_ack));
    if (ack) begin
      if (!busy[i]) begin
        check({tg, "_spurious_ack"}, 32'(ack), 32'h0);
      end else begin
        e = exp_q[i].pop_front();
        check({tg, "_rdata"}, rd, e.rdata);
        check({tg, "_err"}, 32'(err), 32'(e.err));
        if (e.lat >= 0) check({tg, "_latency"}, 32'(cyc - t_drive[i]), 32'(e.lat));
      end
      ack_order.push_back(i);
      busy[i] = 1'b0;
    end
    if (!busy[i]) begin
      if (pend_q[i].size() > 0) begin
        r = pend_q[i].pop_front();
        if (i == 0) begin
          cpu_req = 1'b1; cpu_we = r.we; cpu_addr = r.addr; cpu_wdata = r.wdata;
        end else begin
          dbg_req = 1'b1; dbg_we = r.we; dbg_addr = r.addr; dbg_wdata = r.wdata;
        end
        exp_q[i].push_back(exp_for(r));
        t_drive[i] = cyc;
        busy[i]    = 1'b1;
      end else if (i == 0) begin
        cpu_req = 1'b0;
      end else begin
        dbg_req = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (!busy[0] && !busy[1] && pend_q[0].size() == 0 && pend_q[1].size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", 32'(ok), 32'h1);
  endtask

  task automatic wait_mem_req(input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
    end
    check("mem_req_seen", 32'(ok), 32'h1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder: ready after mem_lat waiting cycles, never when negative.
  initial forever begin
    @(negedge clk);
    if (mem_req) begin
      mem_ready = (mem_lat >= 0) && (wait_cnt == mem_lat);
      wait_cnt++;
    end else begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (io_en) begin
      io_cnt++;
      last_io_we    = io_we;
      last_io_addr  = io_addr;
      last_io_wdata = io_wdata;
    end
    if (mem_req) memreq_cnt++;
    if (io_en && mem_req) check("io_mem_overlap", 32'h1, 32'h0);
    if (reset_n) begin
      if (cpu_ack && dbg_ack) check("ack_overlap", 32'h1, 32'h0);
      service(0);
      service(1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int io0, mr0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_io_en", 32'(io_en), 32'h0);
    check("rst_cpu_ack", 32'(cpu_ack), 32'h0);
    check("rst_dbg_ack", 32'(dbg_ack), 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_dbg_rdata", dbg_rdata, 32'h0);
    check("rst_errs", 32'({cpu_err, dbg_err}), 32'h0);

    // Both requesters held from reset: round-robin starting with cpu.
    mem_lat = 0; chk_lat = 1'b0;
    push(0, 1'b0, 32'h0000_0010, 32'h0);
    push(0, 1'b0, 32'h0000_0020, 32'h0);
    push(1, 1'b1, 32'h0000_0080, 32'h1111_2222);
    push(1, 1'b0, 32'h0000_0084, 32'h0);
    #2 reset_n = 1'b1;
    wait_idle(100);
    check("rr_count", 32'(ack_order.size()), 32'd4);
    for (int k = 0; k < 4 && k < ack_order.size(); k++)
      check($sformatf("rr_order_%0d", k), 32'(ack_order[k]), 32'(k % 2));

    // cpu memory read with two wait cycles.
    chk_lat = 1'b1; mem_lat = 2;
    push(0, 1'b0, 32'h0000_0040, 32'h0);
    wait_mem_req(10);
    check("t1_mem_addr", mem_addr, 32'h0000_0040);
    check("t1_mem_we", 32'(mem_we), 32'h0);
    wait_idle(40);
    check("t1_rdata_hold", cpu_rdata, 32'hCAFE_F00D);

    // cpu IO write, then dbg IO read.
    io0 = io_cnt; mr0 = memreq_cnt;
    push(0, 1'b1, 32'hFF00_0004, 32'h0000_00A5);
    wait_idle(40);
    check("t2_io_pulses", 32'(io_cnt - io0), 32'd1);
    check("t2_no_mem_req", 32'(memreq_cnt - mr0), 32'd0);
    check("t2_io_we", 32'(last_io_we), 32'h1);
    check("t2_io_addr", last_io_addr, 32'hFF00_0004);
    check("t2_io_wdata", last_io_wdata, 32'h0000_00A5);
    push(1, 1'b0, 32'hFF00_0010, 32'h0);
    wait_idle(40);

    // dbg read timing out, then a normal cpu read.
    mem_lat = -1; mr0 = memreq_cnt;
    push(1, 1'b0, 32'h0000_1000, 32'h0);
    wait_idle(60);
    check("t4_mem_req_cycles", 32'(memreq_cnt - mr0), 32'd16);
    check("t4_mem_req_low", 32'(mem_req), 32'h0);
    mem_lat = 1;
    push(0, 1'b0, 32'h0000_0044, 32'h0);
    wait_idle(40);

    // Ready on the last allowed cycle wins over the timeout.
    mem_lat = 15;
    push(0, 1'b0, 32'h1234_5678 ^ c_MEM_KEY, 32'h0);
    wait_idle(60);
    check("t5_rdata", cpu_rdata, 32'h1234_5678);

    // Async reset during a cpu memory access; cpu then wins the first tie.
    mem_lat = -1;
    push(0, 1'b0, 32'h0000_0200, 32'h0);
    wait_mem_req(10);
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("ar_mem_req", 32'(mem_req), 32'h0);
    check("ar_io_en", 32'(io_en), 32'h0);
    check("ar_acks", 32'({cpu_ack, dbg_ack}), 32'h0);
    check("ar_cpu_rdata", cpu_rdata, 32'h0);
    busy[0] = 1'b0; busy[1] = 1'b0;
    exp_q[0].delete(); exp_q[1].delete();
    cpu_req = 1'b0; dbg_req = 1'b0;
    ack_order.delete();
    chk_lat = 1'b0; mem_lat = 0;
    push(0, 1'b0, 32'h0000_0300, 32'h0);
    push(1, 1'b0, 32'h0000_0304, 32'h0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    wait_idle(60);
    check("ar_count", 32'(ack_order.size()), 32'd2);
    if (ack_order.size() == 2) begin
      check("ar_first_cpu", 32'(ack_order[0]), 32'd0);
      check("ar_second_dbg", 32'(ack_order[1]), 32'd1);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
